// File: rtl/lct_l1a_evtbuf.sv
// L1A alignment line and event FIFO: tags delayed L1As with BXN, L1A number
// and LCT match flag, and buffers them for readout.
module lct_l1a_evtbuf #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        L1A,
    input  logic        L1A_MATCH,
    input  logic [3:0]  L1FD,
    input  logic        BC0,
    input  logic        RD_EN,
    output logic [36:0] DOUT,
    output logic        DVALID,
    output logic        EMPTY,
    output logic        FULL,
    output logic        OVFL,
    output logic        ORPHAN,
    output logic [23:0] L1ACNT,
    output logic [15:0] MATCHCNT
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   OCC_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   OCC_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [11:0]           BXN_MAX  = 12'd3563;

    logic [11:0] bxn;
    logic [15:0] sr_l1a;
    logic [11:0] sr_bxn [16];
    logic        l1a_d;
    logic [11:0] bxn_d;

    logic [23:0] l1acnt;
    logic [23:0] l1acnt_nxt;
    logic [15:0] matchcnt;
    logic        orphan;

    logic [36:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   occ;
    logic [DEPTH_LOG2:0]   occ_nxt;
    logic                  empty_q;
    logic                  full_q;
    logic                  ovfl;
    logic                  dvalid;
    logic [36:0]           dout;
    logic                  do_rd;
    logic                  do_wr;
    logic [36:0]           entry;

    always_ff @(posedge CLK) begin
        if (RST) begin
            bxn <= '0;
        end else if (BC0) begin
            bxn <= '0;
        end else if (bxn == BXN_MAX) begin
            bxn <= '0;
        end else begin
            bxn <= bxn + 12'd1;
        end
    end

    // Stage 0 holds the L1A seen last clock, so tap N is N+1 clocks late.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sr_l1a <= '0;
            for (int i = 0; i < 16; i++) begin
                sr_bxn[i] <= '0;
            end
        end else begin
            sr_l1a    <= {sr_l1a[14:0], L1A};
            sr_bxn[0] <= bxn;
            for (int i = 1; i < 16; i++) begin
                sr_bxn[i] <= sr_bxn[i-1];
            end
        end
    end

    assign l1a_d      = sr_l1a[L1FD];
    assign bxn_d      = sr_bxn[L1FD];
    assign l1acnt_nxt = l1acnt + 24'd1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            l1acnt   <= '0;
            matchcnt <= '0;
            orphan   <= 1'b0;
        end else begin
            if (l1a_d) begin
                l1acnt <= l1acnt_nxt;
                if (L1A_MATCH && matchcnt != 16'hFFFF) begin
                    matchcnt <= matchcnt + 16'd1;
                end
            end
            if (L1A_MATCH && !l1a_d) begin
                orphan <= 1'b1;
            end
        end
    end

    // A write into a full FIFO only lands if a read frees a slot this clock.
    assign do_rd = RD_EN & ~empty_q;
    assign do_wr = l1a_d & (~full_q | do_rd);
    assign entry = {L1A_MATCH, bxn_d, l1acnt_nxt};

    always_comb begin
        occ_nxt = occ;
        if (do_wr && !do_rd) begin
            occ_nxt = occ + OCC_ONE;
        end else if (do_rd && !do_wr) begin
            occ_nxt = occ - OCC_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_wr) begin
            mem[wptr] <= entry;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr    <= '0;
            rptr    <= '0;
            occ     <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovfl    <= 1'b0;
            dvalid  <= 1'b0;
            dout    <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + PTR_ONE;
            end
            if (do_rd) begin
                rptr <= rptr + PTR_ONE;
                dout <= mem[rptr];
            end
            if (l1a_d && full_q && !do_rd) begin
                ovfl <= 1'b1;
            end
            dvalid  <= do_rd;
            occ     <= occ_nxt;
            empty_q <= (occ_nxt == '0);
            full_q  <= (occ_nxt == OCC_FULL);
        end
    end

    assign DOUT     = dout;
    assign DVALID   = dvalid;
    assign EMPTY    = empty_q;
    assign FULL     = full_q;
    assign OVFL     = ovfl;
    assign ORPHAN   = orphan;
    assign L1ACNT   = l1acnt;
    assign MATCHCNT = matchcnt;

endmodule

// File: tb/tb_lct_l1a_evtbuf.sv
// Directed bench for lct_l1a_evtbuf: expected event words are queued at
// stimulus time and compared as DVALID words emerge.
module tb_lct_l1a_evtbuf;

    logic        CLK = 1'b0;
    logic        RST;
    logic        L1A;
    logic        L1A_MATCH;
    logic [3:0]  L1FD;
    logic        BC0;
    logic        RD_EN;
    logic [36:0] DOUT;
    logic        DVALID;
    logic        EMPTY;
    logic        FULL;
    logic        OVFL;
    logic        ORPHAN;
    logic [23:0] L1ACNT;
    logic [15:0] MATCHCNT;

    int n_cmp = 0;
    int n_err = 0;
    logic [36:0] sb [$];

    lct_l1a_evtbuf #(.DEPTH_LOG2(4)) dut (
        .CLK(CLK), .RST(RST), .L1A(L1A), .L1A_MATCH(L1A_MATCH),
        .L1FD(L1FD), .BC0(BC0), .RD_EN(RD_EN), .DOUT(DOUT),
        .DVALID(DVALID), .EMPTY(EMPTY), .FULL(FULL), .OVFL(OVFL),
        .ORPHAN(ORPHAN), .L1ACNT(L1ACNT), .MATCHCNT(MATCHCNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge CLK);
    endtask

    task automatic do_reset;
        check("sb_drained", sb.size(), 0);
        RST = 1'b1; L1A = 1'b0; L1A_MATCH = 1'b0; BC0 = 1'b0; RD_EN = 1'b0;
        tick; tick;
        RST = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (DVALID) begin
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_dvalid: observed %0h expected none", DOUT);
            end
            if (sb.size() > 0) check("dout", DOUT, sb.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; L1A = 1'b0; L1A_MATCH = 1'b0; BC0 = 1'b0;
        RD_EN = 1'b0; L1FD = 4'd0;
        do_reset;
        check("rst_empty", EMPTY, 1);
        check("rst_full", FULL, 0);
        check("rst_dvalid", DVALID, 0);
        check("rst_dout", DOUT, 0);
        check("rst_ovfl", OVFL, 0);
        check("rst_orphan", ORPHAN, 0);
        check("rst_l1acnt", L1ACNT, 0);
        check("rst_matchcnt", MATCHCNT, 0);

        // Matched event at BXN 10 with fine delay 5
        L1FD = 4'd5;
        BC0 = 1'b1; tick; BC0 = 1'b0;
        repeat (10) tick;
        L1A = 1'b1;
        sb.push_back({1'b1, 12'h00A, 24'h000001});
        tick; L1A = 1'b0;
        repeat (5) tick;
        L1A_MATCH = 1'b1; tick; L1A_MATCH = 1'b0;
        check("m_l1acnt", L1ACNT, 1);
        check("m_matchcnt", MATCHCNT, 1);
        check("m_empty", EMPTY, 0);
        check("m_orphan", ORPHAN, 0);
        RD_EN = 1'b1; tick; RD_EN = 1'b0;
        check("m_dvalid", DVALID, 1);
        tick;
        check("m_dvalid_1clk", DVALID, 0);
        check("m_empty_after", EMPTY, 1);
        RD_EN = 1'b1; tick; RD_EN = 1'b0;
        check("rd_empty_dvalid", DVALID, 0);
        check("rd_empty_hold", DOUT, 37'h1_00A_000001);

        // Orphan match
        do_reset;
        L1FD = 4'd15;
        L1A_MATCH = 1'b1; tick; L1A_MATCH = 1'b0; tick;
        check("orph_flag", ORPHAN, 1);
        check("orph_empty", EMPTY, 1);
        check("orph_l1acnt", L1ACNT, 0);
        check("orph_matchcnt", MATCHCNT, 0);

        // Overflow: 17 back-to-back L1As
        do_reset;
        L1FD = 4'd0;
        BC0 = 1'b1; tick; BC0 = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            L1A = 1'b1;
            if (i <= 16) sb.push_back({1'b0, 12'(i-1), 24'(i)});
            tick;
        end
        check("ov_full16", FULL, 1);
        check("ov_noovfl16", OVFL, 0);
        L1A = 1'b0; tick;
        check("ov_ovfl", OVFL, 1);
        check("ov_full", FULL, 1);
        check("ov_l1acnt", L1ACNT, 17);
        RD_EN = 1'b1; repeat (16) tick; RD_EN = 1'b0; tick;
        check("ov_empty", EMPTY, 1);
        check("ov_notfull", FULL, 0);

        // Full FIFO with write and read on the same clock
        do_reset;
        L1FD = 4'd0;
        BC0 = 1'b1; tick; BC0 = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            L1A = 1'b1;
            sb.push_back({1'b0, 12'(i-1), 24'(i)});
            tick;
        end
        L1A = 1'b0; RD_EN = 1'b1; tick; RD_EN = 1'b0;
        check("wr_rd_full", FULL, 1);
        check("wr_rd_ovfl", OVFL, 0);
        check("wr_rd_l1acnt", L1ACNT, 17);
        check("wr_rd_dvalid", DVALID, 1);
        RD_EN = 1'b1; repeat (15) tick;
        check("wr_rd_last_left", EMPTY, 0);
        tick; RD_EN = 1'b0; tick;
        check("wr_rd_empty", EMPTY, 1);

        // Reset discards L1A still in the alignment line
        do_reset;
        L1FD = 4'd15;
        L1A = 1'b1; tick; L1A = 1'b0;
        repeat (7) tick;
        RST = 1'b1; tick; RST = 1'b0;
        repeat (20) tick;
        check("inflight_empty", EMPTY, 1);
        check("inflight_l1acnt", L1ACNT, 0);

        // BXN wraps 3563 -> 0 without BC0
        do_reset;
        L1FD = 4'd0;
        BC0 = 1'b1; tick; BC0 = 1'b0;
        repeat (3563) tick;
        L1A = 1'b1;
        sb.push_back({1'b0, 12'd3563, 24'd1});
        tick;
        sb.push_back({1'b0, 12'd0, 24'd2});
        tick; L1A = 1'b0; tick;
        RD_EN = 1'b1; repeat (2) tick; RD_EN = 1'b0; tick;
        check("bxwrap_empty", EMPTY, 1);
        check("bxwrap_l1acnt", L1ACNT, 2);

        // L1A number wraps FFFFFF -> 000000
        do_reset;
        L1FD = 4'd0;
        force dut.l1acnt = 24'hFFFFFF;
        BC0 = 1'b1; tick; BC0 = 1'b0;
        L1A = 1'b1;
        sb.push_back({1'b1, 12'd0, 24'h000000});
        tick; L1A = 1'b0;
        L1A_MATCH = 1'b1; tick; L1A_MATCH = 1'b0;
        release dut.l1acnt;
        check("numwrap_matchcnt", MATCHCNT, 1);
        RD_EN = 1'b1; tick; RD_EN = 1'b0; tick;
        check("numwrap_empty", EMPTY, 1);

        check("sb_final", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lct_l1a_evtbuf.md
LCT_L1A_EVTBUF -- requirements
Module: lct_l1a_evtbuf

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, log2 of event FIFO depth (16 entries).
REQ-002 CLK  input  1  system clock; all logic on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 L1A  input  1  Level-1 accept strobe, undelayed; one pulse per accept, may assert on consecutive clocks.
REQ-005 L1A_MATCH  input  1  LCT/L1A match strobe from LCT delay stage; aligned to L1A delayed by L1FD+1 clocks.
REQ-006 L1FD  input  4  L1A fine delay setting; static during operation.
REQ-007 BC0  input  1  bunch-crossing-zero strobe.
REQ-008 RD_EN  input  1  readout request, one entry per clock.
REQ-009 DOUT  output  37  event word {MATCH, BXN[11:0], L1ANUM[23:0]}.
REQ-010 DVALID  output  1  DOUT valid, one clock per popped entry.
REQ-011 EMPTY  output  1  FIFO holds no entries.
REQ-012 FULL  output  1  FIFO holds 2^DEPTH_LOG2 entries.
REQ-013 OVFL  output  1  sticky: event dropped due to full FIFO.
REQ-014 ORPHAN  output  1  sticky: L1A_MATCH seen with no aligned delayed L1A.
REQ-015 L1ACNT  output  24  count of accepted (delayed) L1As.
REQ-016 MATCHCNT  output  16  count of matched L1As, saturating.

Function
REQ-017 BXN counter: 12 bits; BC0=1 -> 0 next clock; else 3563 -> 0; else +1.
REQ-018 Alignment line: 16-stage shift register of {L1A, BXN}; tap L1FD gives L1A_D and BXN_D exactly L1FD+1 clocks after L1A (L1FD=0 -> 1 clock, L1FD=15 -> 16 clocks).
REQ-019 BXN_D equals BXN value in the clock L1A was high.
REQ-020 On L1A_D=1: L1ACNT increments (24-bit wrap FFFFFF -> 000000) regardless of FIFO state.
REQ-021 On L1A_D=1: write entry {L1A_MATCH, BXN_D, L1ACNT+1}; first event after reset carries L1ANUM=1.
REQ-022 On L1A_D=1 and L1A_MATCH=1: MATCHCNT increments, holds at FFFF.
REQ-023 L1A_MATCH=1 with L1A_D=0: no write, no count, ORPHAN set.
REQ-024 FIFO: circular buffer, 2^DEPTH_LOG2 entries, write/read pointers DEPTH_LOG2 bits wrapping, occupancy DEPTH_LOG2+1 bits.
REQ-025 Read: RD_EN=1 and EMPTY=0 -> oldest entry on DOUT with DVALID=1 next clock; 1-clock latency.
REQ-026 RD_EN=1 with EMPTY=1: ignored, DVALID=0, DOUT holds.
REQ-027 Write with FULL=1 and no same-clock read: entry dropped, OVFL set, pointers unchanged.
REQ-028 Write and read same clock with FULL=1: both performed, occupancy unchanged, no OVFL.
REQ-029 Write and read same clock with EMPTY=1: write only; read ignored (no bypass).
REQ-030 FULL/EMPTY registered, reflect occupancy after current clock's operations.
REQ-031 Ordering: entries read in write order; no loss except REQ-027.

Reset
REQ-032 RST=1: BXN, shift register, pointers, occupancy, L1ACNT, MATCHCNT cleared; OVFL, ORPHAN, DVALID=0; EMPTY=1; FULL=0; DOUT=0.
REQ-033 L1A or RD_EN in a reset clock ignored; L1As in flight in alignment line at reset discarded.
REQ-034 Reset mid-operation takes effect next clock regardless of FIFO/line contents.

Verification
REQ-035 L1FD=5, BC0 then L1A at BXN=10 with L1A_MATCH pulsed 6 clocks later, RD_EN -> DOUT={1,0x00A,0x000001}, DVALID 1 clock, MATCHCNT=1.
REQ-036 L1FD=0, 17 L1As on consecutive clocks, no reads -> FULL after 16th write, OVFL=1, L1ACNT=17, first 16 entries read back L1ANUM 1..16 in order.
REQ-037 FIFO full, L1A_D and RD_EN same clock -> occupancy 16, OVFL=0, oldest entry output.
REQ-038 L1A_MATCH pulse with no L1A 16 clocks prior -> ORPHAN=1, EMPTY=1, counts 0.
REQ-039 L1FD=15, L1A then RST 8 clocks later -> no entry written, L1ACNT=0, EMPTY=1 after reset.
REQ-040 Preload L1ACNT path to FFFFFF (3 events after forced count or long run) -> next entry L1ANUM=000000; BXN wraps 3563 -> 0 without BC0.
